// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back data cache between the MEM stage and a block-wide
// data memory. Hits complete in one cycle. A miss stalls the pipeline, writes
// back a dirty victim line in one full-block write, then refills the line with
// one full-block read. Each memory transaction is held for MEM_LAT cycles.
module dcache_ctrl #(
  parameter int BLOCK_SIZE = 8,
  parameter int NUM_LINES  = 16,
  parameter int MEM_LAT    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_re,
  input  logic                    cpu_we,
  input  logic [31:0]             cpu_a,
  input  logic [31:0]             cpu_wd,
  output logic [31:0]             cpu_rd,
  output logic                    stall,
  output logic                    mem_we,
  output logic [31:0]             mem_a,
  output logic [BLOCK_SIZE*32-1:0] mem_wd,
  input  logic [BLOCK_SIZE*32-1:0] mem_rd
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = 32 - 5 - INDEX_W;
  localparam int CNT_W   = $clog2(MEM_LAT) + 1;
  localparam int LINE_W  = BLOCK_SIZE * 32;

  typedef enum logic [1:0] {IDLE, WBACK, REFILL} state_t;

  // Address fields of the current request.
  logic [2:0]         off;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [31:0]        blk_a;

  assign off   = cpu_a[4:2];
  assign idx   = cpu_a[5 +: INDEX_W];
  assign tag   = cpu_a[31 -: TAG_W];
  assign blk_a = {cpu_a[31:5], 5'b0};

  // Byte-lane bits are not used by a word cache.
  logic unused_byte_bits;
  assign unused_byte_bits = ^cpu_a[1:0];

  // Control and status state.
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   mem_we_q, mem_we_d;
  logic [31:0]            mem_a_q, mem_a_d;
  logic [LINE_W-1:0]      mem_wd_q, mem_wd_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic [NUM_LINES-1:0]   dirty_q, dirty_d;

  // Tag and data storage.
  logic [TAG_W-1:0]       tag_q  [NUM_LINES];
  logic [LINE_W-1:0]      data_q [NUM_LINES];

  // Array write controls, decided alongside the next state.
  logic                   word_we;
  logic                   line_fill;

  logic req;
  logic hit;

  assign req = cpu_re | cpu_we;
  assign hit = valid_q[idx] && (tag_q[idx] == tag);

  assign cpu_rd = hit ? data_q[idx][{off, 5'b0} +: 32] : 32'h0;
  assign stall  = (state_q != IDLE) || (req && !hit);

  assign mem_we = mem_we_q;
  assign mem_a  = mem_a_q;
  assign mem_wd = mem_wd_q;

  // Next-state logic for the miss FSM, line status bits and memory outputs.
  // NOTE: every signal gets a default at the top so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we_d  = mem_we_q;
    mem_a_d   = mem_a_q;
    mem_wd_d  = mem_wd_q;
    valid_d   = valid_q;
    dirty_d   = dirty_q;
    word_we   = 1'b0;
    line_fill = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            // A store wins when both request strobes are high.
            if (cpu_we) begin
              word_we      = 1'b1;
              dirty_d[idx] = 1'b1;
            end
          end else begin
            cnt_d = CNT_W'(MEM_LAT - 1);
            if (valid_q[idx] && dirty_q[idx]) begin
              state_d  = WBACK;
              mem_we_d = 1'b1;
              mem_a_d  = {tag_q[idx], idx, 5'b0};
              mem_wd_d = data_q[idx];
            end else begin
              state_d  = REFILL;
              mem_we_d = 1'b0;
              mem_a_d  = blk_a;
            end
          end
        end
      end

      WBACK: begin
        if (cnt_q == '0) begin
          state_d      = REFILL;
          mem_we_d     = 1'b0;
          mem_a_d      = blk_a;
          cnt_d        = CNT_W'(MEM_LAT - 1);
          dirty_d[idx] = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      REFILL: begin
        if (cnt_q == '0) begin
          state_d      = IDLE;
          line_fill    = 1'b1;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Control registers; reset abandons any transaction in flight.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mem_we_q <= 1'b0;
      mem_a_q  <= '0;
      mem_wd_q <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mem_we_q <= mem_we_d;
      mem_a_q  <= mem_a_d;
      mem_wd_q <= mem_wd_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
    end
  end

  // Tag and data arrays: refill replaces a whole line, a store hit one word.
  // NOTE: the arrays have no reset; valid_q gates every use of their contents.
  always_ff @(posedge clk) begin
    if (line_fill) begin
      data_q[idx] <= mem_rd;
      tag_q[idx]  <= tag;
    end else if (word_we) begin
      data_q[idx][{off, 5'b0} +: 32] <= cpu_wd;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed vector table, a reset-during-
// writeback sequence, then random loads/stores against a behavioural model.
module tb_dcache_ctrl;

  localparam int BS      = 8;
  localparam int MEM_LAT = 4;
  localparam int CLEAN_PEN = MEM_LAT + 1;
  localparam int DIRTY_PEN = 2 * MEM_LAT + 1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            cpu_re = 1'b0;
  logic            cpu_we = 1'b0;
  logic [31:0]     cpu_a = '0;
  logic [31:0]     cpu_wd = '0;
  logic [31:0]     cpu_rd;
  logic            stall;
  logic            mem_we;
  logic [31:0]     mem_a;
  logic [BS*32-1:0] mem_wd;
  logic [BS*32-1:0] mem_rd;

  dcache_ctrl #(.BLOCK_SIZE(BS), .NUM_LINES(16), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .stall(stall),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Backing block memory (64 KB), word addressed.
  logic [31:0] tb_mem [16384];
  logic [13:0] mem_wa;
  assign mem_wa = mem_a[15:2];

  always_comb begin
    for (int i = 0; i < BS; i++) mem_rd[i*32 +: 32] = tb_mem[mem_wa + 14'(i)];
  end

  always @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BS; i++) tb_mem[mem_wa + 14'(i)] <= mem_wd[i*32 +: 32];
    end
  end

  function automatic logic [31:0] init_word(input int w);
    return 32'h5EED_0000 ^ (w * 32'h0001_9E37);
  endfunction

  // The request address must not move while the cache is stalling.
  logic        last_stall = 1'b0;
  logic [31:0] last_addr = '0;
  always @(negedge clk) begin
    if (reset) begin
      last_stall <= 1'b0;
    end else begin
      assert (!(last_stall && cpu_a != last_addr))
        else $error("cpu_a changed while stall was high");
      last_stall <= stall;
      last_addr  <= cpu_a;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Observations from the most recent access.
  int               got_stall;
  int               got_we;
  logic [31:0]      got_rd;
  logic [31:0]      wb_a;
  logic [BS*32-1:0] wb_wd;
  logic [31:0]      fin_a;
  logic             timed_out;

  // Issue one request, hold it while stalled, sample the hit-cycle result.
  task automatic access(input logic re, input logic we, input logic [31:0] a,
                        input logic [31:0] wd);
    @(posedge clk); #1;
    cpu_re = re; cpu_we = we; cpu_a = a; cpu_wd = wd;
    got_stall = 0; got_we = 0; timed_out = 1'b0;
    wb_a = '0; wb_wd = '0; fin_a = '0;
    @(negedge clk);
    while (stall && !timed_out) begin
      got_stall++;
      if (mem_we) begin
        if (got_we == 0) begin
          wb_a  = mem_a;
          wb_wd = mem_wd;
        end
        got_we++;
      end
      fin_a = mem_a;
      if (got_stall > 40) timed_out = 1'b1;
      else @(negedge clk);
    end
    got_rd = cpu_rd;
    @(posedge clk); #1;
    cpu_re = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic        re;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    int          exp_stall;
    int          exp_we;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [31:0] exp_ma;   // refill block address seen at the end of the stall
    logic [31:0] exp_wba;  // writeback block address
    int          wb_word;
    logic [31:0] exp_wbd;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model for the random phase.
  logic [31:0] smem [16384];
  logic        m_valid [16];
  int          m_tag   [16];
  logic        m_dirty [16];

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    for (int i = 0; i < 16384; i++) tb_mem[i] = init_word(i);

    // Reset state.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset cpu_rd", cpu_rd, 32'h0);
    check("reset stall", {31'b0, stall}, 32'h0);
    check("reset mem_we", {31'b0, mem_we}, 32'h0);
    check("reset mem_a", mem_a, 32'h0);
    #1 reset = 1'b0;

    //          re    we    addr          wdata          stl        we rd   exp_rd                    ma            wba          w  wbd
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0100, 32'h0,         CLEAN_PEN, 0, 1'b1, init_word(32'h100 >> 2),  32'h0000_0100, 32'h0,        0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0104, 32'h0,         0,         0, 1'b1, init_word(32'h104 >> 2),  32'h0,        32'h0,        0, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0108, 32'hDEADBEEF,  0,         0, 1'b0, 32'h0,                    32'h0,        32'h0,        0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0108, 32'h0,         0,         0, 1'b1, 32'hDEADBEEF,             32'h0,        32'h0,        0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_2108, 32'h0,         DIRTY_PEN, 4, 1'b1, init_word(32'h2108 >> 2), 32'h0000_2100, 32'h0000_0100, 2, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0108, 32'h0,         CLEAN_PEN, 0, 1'b1, 32'hDEADBEEF,             32'h0000_0100, 32'h0,        0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_2100, 32'h0,         CLEAN_PEN, 0, 1'b1, init_word(32'h2100 >> 2), 32'h0000_2100, 32'h0,        0, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0400, 32'h12345678,  CLEAN_PEN, 0, 1'b0, 32'h0,                    32'h0000_0400, 32'h0,        0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0400, 32'h0,         0,         0, 1'b1, 32'h12345678,             32'h0,        32'h0,        0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_4400, 32'h0,         DIRTY_PEN, 4, 1'b1, init_word(32'h4400 >> 2), 32'h0000_4400, 32'h0000_0400, 0, 32'h12345678});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0400, 32'h0,         CLEAN_PEN, 0, 1'b1, 32'h12345678,             32'h0000_0400, 32'h0,        0, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 32'h0000_0404, 32'hCAFEF00D,  0,         0, 1'b0, 32'h0,                    32'h0,        32'h0,        0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0404, 32'h0,         0,         0, 1'b1, 32'hCAFEF00D,             32'h0,        32'h0,        0, 32'h0});

    foreach (vecs[k]) begin
      vec_t v;
      v = vecs[k];
      access(v.re, v.we, v.a, v.wd);
      check($sformatf("v%0d timeout", k), {31'b0, timed_out}, 32'h0);
      check($sformatf("v%0d stall cycles", k), got_stall, v.exp_stall);
      check($sformatf("v%0d write cycles", k), got_we, v.exp_we);
      if (v.chk_rd) check($sformatf("v%0d cpu_rd", k), got_rd, v.exp_rd);
      if (v.exp_stall > 0) check($sformatf("v%0d refill mem_a", k), fin_a, v.exp_ma);
      if (v.exp_we > 0) begin
        check($sformatf("v%0d wback mem_a", k), wb_a, v.exp_wba);
        check($sformatf("v%0d wback word", k), wb_wd[v.wb_word*32 +: 32], v.exp_wbd);
      end
    end
    check("mem 0x108 written back", tb_mem[32'h108 >> 2], 32'hDEADBEEF);
    check("mem 0x400 written back", tb_mem[32'h400 >> 2], 32'h12345678);

    // Reset during the second cycle of a writeback.
    pulse_reset();
    access(1'b1, 1'b0, 32'h0000_0100, 32'h0);
    check("rst seq cold miss", got_stall, CLEAN_PEN);
    access(1'b0, 1'b1, 32'h0000_0104, 32'h0BAD_F00D);
    check("rst seq store hit", got_stall, 0);
    @(posedge clk); #1;
    cpu_re = 1'b1; cpu_a = 32'h0000_2100;
    begin : wait_wback
      int we_seen;
      int cyc;
      we_seen = 0;
      cyc = 0;
      while (we_seen < 2 && cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (mem_we) we_seen++;
      end
      check("rst seq reached wback", we_seen, 2);
    end
    #1;
    reset  = 1'b1;
    cpu_re = 1'b0;
    #1;
    check("rst seq mem_we", {31'b0, mem_we}, 32'h0);
    check("rst seq stall", {31'b0, stall}, 32'h0);
    @(negedge clk); #1;
    reset = 1'b0;
    access(1'b1, 1'b0, 32'h0000_0100, 32'h0);
    check("rst seq reload misses", got_stall, CLEAN_PEN);

    // Random phase: model is a flat memory plus per-line valid/tag/dirty.
    pulse_reset();
    for (int i = 0; i < 16384; i++) smem[i] = tb_mem[i];
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_dirty[i] = 1'b0;
    end
    for (int k = 0; k < 300; k++) begin
      int          li;
      int          tg;
      int          wo;
      int          op;
      int          e_stall;
      int          e_we;
      logic [31:0] a;
      logic [31:0] wd;
      logic        is_st;
      li = int'($urandom_range(0, 15));
      tg = int'($urandom_range(0, 3));
      wo = int'($urandom_range(0, 7));
      op = int'($urandom_range(0, 2));
      a  = 32'(tg * 512 + li * 32 + wo * 4);
      wd = $urandom;
      is_st = (op != 0);

      if (m_valid[li] && m_tag[li] == tg) begin
        e_stall = 0;
        e_we    = 0;
      end else begin
        e_stall = (m_valid[li] && m_dirty[li]) ? DIRTY_PEN : CLEAN_PEN;
        e_we    = (m_valid[li] && m_dirty[li]) ? MEM_LAT : 0;
        m_valid[li] = 1'b1;
        m_tag[li]   = tg;
        m_dirty[li] = 1'b0;
      end

      access(op != 1, is_st, a, wd);
      check($sformatf("rnd%0d stall cycles", k), got_stall, e_stall);
      check($sformatf("rnd%0d write cycles", k), got_we, e_we);
      if (is_st) begin
        m_dirty[li] = 1'b1;
        smem[a[15:2]] = wd;
      end else begin
        check($sformatf("rnd%0d load data", k), got_rd, smem[a[15:2]]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back data cache between the pipeline MEM stage and the 8-word block data memory.
- Serves 32-bit word loads and stores in one cycle on a hit.
- On a miss, stalls the pipeline and evicts the victim line if it is dirty, using a full-block memory write.
- Then refills the line with a full-block memory read, using the same block interface width as the memory (BLOCK_SIZE*32 bits).

Parameters:
- BLOCK_SIZE, 8: words per line; fixed to 8 to match the memory block and 5-bit block offset.
- NUM_LINES, 16: cache lines; power of 2. INDEX_W = log2(NUM_LINES).
- MEM_LAT, 4: cycles each memory transaction is held. MEM_LAT × clock period must exceed the memory's 30 ns input delay plus one cycle.

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- cpu_re  input  1  load request.
- cpu_we  input  1  store request.
- cpu_a  input  32  byte address; bits [1:0] ignored.
- cpu_wd  input  32  store data.
- cpu_rd  output  32  load data; combinational, valid on hit.
- stall  output  1  pipeline must hold request and address stable while high.
- mem_we  output  1  block write enable to memory.
- mem_a  output  32  block address to memory; bits [4:0] always 0.
- mem_wd  output  BLOCK_SIZE*32  block write data; word i at bits [32i+31:32i].
- mem_rd  input  BLOCK_SIZE*32  block read data from memory.

Behaviour:
- Address split:
  - word offset = cpu_a[4:2]
  - index = cpu_a[5+INDEX_W-1:5]
  - tag = cpu_a[31:5+INDEX_W]
- Per-line state: valid, dirty, tag, 8×32 data.
- req = cpu_re | cpu_we. hit = valid[index] & (tag[index] == tag).
- cpu_rd = data[index][offset] whenever hit; otherwise 0.
- stall = (state != IDLE) | (req & ~hit). Combinational; rises in the same cycle as a missing request.
- Store hit in IDLE: at posedge, write the word and set dirty[index]=1; no stall.
- If cpu_re and cpu_we are both high, the access is a store.
- FSM states: IDLE, WBACK, REFILL.
- IDLE, on req & ~hit:
  - If valid & dirty, go to WBACK. Register mem_a = {old tag, index, 5'b0}, mem_wd = line data, mem_we = 1.
  - Otherwise go to REFILL. Register mem_a = {cpu_a[31:5], 5'b0}, mem_we = 0.
  - Load the cycle counter with MEM_LAT-1.
- WBACK:
  - Hold mem_we/mem_a/mem_wd stable and decrement the counter.
  - When the counter is 0: mem_we = 0, mem_a = refill address, counter = MEM_LAT-1, go to REFILL.
  - Clear dirty[index] on exit.
- REFILL:
  - Hold mem_a stable and decrement the counter.
  - When the counter is 0: capture mem_rd into the line, set valid=1, dirty=0, tag=tag, go to IDLE.
- On the cycle after returning to IDLE, the held request hits. stall drops and the load/store completes through the normal hit path.
- Miss penalty: MEM_LAT+1 stall cycles when the victim is clean, 2·MEM_LAT+1 when it is dirty.
- mem_a, mem_we, mem_wd are registered outputs and never change mid-transaction.
- Reset (async, any state, including mid-WBACK/REFILL):
  - state=IDLE, all valid=0, dirty=0, counter=0, mem_we=0, mem_a=0, mem_wd=0.
  - An in-flight writeback is abandoned and its dirty data is lost.
- After reset, cpu_rd=0. stall=0 while req=0, and stall=1 on any request because every line misses.
- Changing cpu_a while stall=1 is illegal; behaviour is undefined and the testbench checks this with an assertion.
- No memory transaction starts while req=0.

Test Plan:
- Cold load: reset; load 0x0000_0100. Required: stall high for MEM_LAT+1=5 cycles; mem_a=0x100; mem_we never high; cpu_rd equals memory word 0x100 on the 6th cycle with stall=0.
- Hit path: after the refill above, load 0x0000_0104 and store 0xDEADBEEF to 0x108, then load 0x108. Required: stall=0 throughout; final cpu_rd=0xDEADBEEF; no memory activity.
- Dirty eviction: after the store above, load 0x0000_2108 (same index 8, different tag). Required: WBACK with mem_we=1 and mem_a=0x100 for 4 cycles, where mem_wd word 2 = 0xDEADBEEF. Then REFILL at mem_a=0x2100, total stall 9 cycles. Reloading 0x108 then fetches 0xDEADBEEF from memory.
- Clean eviction: load 0x100, then load 0x2100. Required: no WBACK state and mem_we stays 0; stall is 5 cycles.
- Store miss: store 0x12345678 to 0x400 on a cold cache. Required: refill of 0x400 block, then the word is written; dirty=1; a later eviction writes back 0x12345678 at word 0.
- Reset mid-WBACK: assert reset in cycle 2 of WBACK. Required: mem_we=0 and stall drops immediately (req low); the next load of 0x100 misses.
